// File: rtl/dec_scan_sel_pkg.sv
// Shared constants and helpers for the scan/direct one-hot selector.
package dec_scan_sel_pkg;

  // Encodings of the mode input
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Operating state, derived fresh every cycle from enab/mode
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } st_t;

  // Map the enable and mode inputs onto the operating state
  function automatic st_t eval_state(input logic enab, input logic mode);
    if (!enab)
      return ST_OFF;
    if (mode == MODE_SCAN)
      return ST_SCAN;
    return ST_DIRECT;
  endfunction

  // Bits needed to hold 0..p-1, never less than one
  function automatic int pre_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/dec_scan_sel_onehot.sv
// Combinational index to one-hot decoder feeding the select register.
module dec_onehot #(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] oh
);

  // Exactly one bit set, at position sel
  always_comb begin
    oh      = '0;
    oh[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_scan_sel.sv
// One-hot select generator: direct decode of inp, or automatic scan of
// all indices at one step per PRESCALE cycles. All outputs are flops.
module dec_scan_sel
  import dec_scan_sel_pkg::*;
#(
  parameter int N        = 3,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    inp,
  input  logic            enab,
  input  logic            mode,
  output logic [2**N-1:0] d,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int          W    = 2**N;
  localparam int          PW   = pre_width(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  IMAX = '1;

  st_t          st;
  logic [PW-1:0] pre;
  logic         step;
  logic [N-1:0] idx_nxt;
  logic [W-1:0] oh;

  // Operating state is not stored; it follows enab/mode every cycle
  always_comb st = eval_state(enab, mode);

  assign step = (st == ST_SCAN) && (pre == PMAX);

  // Index that will be presented after this edge; d is decoded from it so
  // d and idx always agree
  always_comb begin
    idx_nxt = idx;
    unique case (st)
      ST_DIRECT: idx_nxt = inp;
      ST_SCAN:   if (step) idx_nxt = idx + 1'b1;
      default:   idx_nxt = idx;
    endcase
  end

  dec_onehot #(.N(N)) u_onehot (
    .sel (idx_nxt),
    .oh  (oh)
  );

  // Output, index and prescaler registers. DIRECT keeps the prescaler at
  // zero so a later switch to SCAN waits a full PRESCALE interval; OFF
  // freezes idx and prescaler so scanning resumes where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      d    <= '0;
      idx  <= '0;
      pre  <= '0;
      wrap <= 1'b0;
    end else begin
      unique case (st)
        ST_OFF: begin
          d    <= '0;
          wrap <= 1'b0;
        end
        ST_DIRECT: begin
          d    <= oh;
          idx  <= idx_nxt;
          pre  <= '0;
          wrap <= 1'b0;
        end
        ST_SCAN: begin
          d    <= oh;
          idx  <= idx_nxt;
          pre  <= step ? '0 : pre + 1'b1;
          wrap <= step && (idx == IMAX);
        end
        default: begin
          d    <= '0;
          wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dec_scan_sel.md
DEC_SCAN_SEL -- requirements
Module: dec_scan_sel

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter PRESCALE, default 4: clock cycles per scan step; legal range 1..65535.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port inp  input  N: index to decode in direct mode.
REQ-006 Port enab  input  1: 1 = block active; 0 = outputs forced low.
REQ-007 Port mode  input  1: 0 = direct decode, 1 = automatic scan.
REQ-008 Port d  output  2**N: registered one-hot select; all-zero when disabled, never high-impedance.
REQ-009 Port idx  output  N: registered index currently driven on d.
REQ-010 Port wrap  output  1: one-cycle pulse when the scan index rolls from 2**N-1 to 0.

Function
REQ-011 The block SHALL hold three states: OFF (enab=0), DIRECT (enab=1, mode=0) and SCAN (enab=1, mode=1); the state is re-evaluated every cycle from enab and mode.
REQ-012 In OFF, d SHALL be all-zero from the next edge; idx and the prescaler SHALL hold their values; wrap SHALL be 0.
REQ-013 In DIRECT, on each edge d SHALL become one-hot of inp (bit inp set, all others 0) and idx SHALL become inp; latency from inp to d is exactly one cycle.
REQ-014 In SCAN, a prescale counter SHALL count 0..PRESCALE-1; on the edge where it equals PRESCALE-1, it SHALL clear to 0 and idx SHALL increment modulo 2**N.
REQ-015 In SCAN, d SHALL equal one-hot of the idx value present after that edge, so d and idx always agree.
REQ-016 With PRESCALE=1, idx SHALL advance on every SCAN cycle.
REQ-017 The wrap output SHALL be 1 for exactly the cycle following the edge on which idx changes from 2**N-1 to 0 in SCAN; it SHALL be 0 otherwise, including on DIRECT loads of 0.
REQ-018 A transition DIRECT->SCAN SHALL clear the prescaler and start scanning from the current idx, so the first step occurs PRESCALE cycles later.
REQ-019 A transition OFF->SCAN SHALL resume with the held prescaler value and idx; d SHALL become one-hot(idx) on the first enabled edge.
REQ-020 A transition SCAN->DIRECT SHALL load inp on that edge, discarding the scan position.
REQ-021 Prescaler width SHALL be the minimum number of bits for PRESCALE-1, with a minimum of 1 bit; no overflow is possible.
REQ-022 d SHALL never have more than one bit set in any cycle.

Reset
REQ-023 While rst=1 at an edge, d SHALL be 0, idx 0, prescaler 0 and wrap 0, overriding enab and mode.
REQ-024 Deassertion of rst mid-scan SHALL restart scanning from idx=0 with a full PRESCALE interval before the first step.

Structure
REQ-025 The mode encodings (DIRECT=0, SCAN=1) and the state encodings (OFF, DIRECT, SCAN) SHALL be defined as constants in the shared package.
REQ-026 Index-to-one-hot conversion SHALL be a single combinational sub-module, dec_onehot (parameter N), instantiated once and feeding the d register.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from the inputs to the outputs.

Verification (N=3, PRESCALE=4)
REQ-028 Reset: hold rst=1 with enab=1, mode=1, inp=5 for 3 cycles -> d=8'h00, idx=0, wrap=0 throughout.
REQ-029 Direct: enab=1, mode=0, inp stepped 0..7 each cycle -> d one cycle later =8'h01,8'h02,...,8'h80, and idx equals inp delayed one cycle.
REQ-030 Scan: enab=1, mode=1 from reset -> idx advances every 4 cycles 0->1->...->7->0; d=8'h80 then 8'h01 at wrap; wrap=1 for one cycle only.
REQ-031 Disable mid-scan: at idx=3, prescaler=2, drop enab for 5 cycles -> d=0 and idx=3 held; on re-enable, d=8'h08 and idx=4 after 2 more cycles.
REQ-032 Mode switch: DIRECT with inp=6, then mode=1 -> d=8'h40 held for 4 cycles, then 8'h80, then 8'h01 with a wrap pulse.
REQ-033 Sync reset mid-scan at idx=6 -> idx=0, d=8'h01 on the first cycle after release, next step after 4 cycles; PRESCALE=1 rerun gives idx+1 every cycle.
